// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM state encoding,
// the bundle of hazard control outputs and the load-use compare helper.
package hazard_pkg;

  localparam int unsigned LU_CNT_W = 3;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // Control outputs that the hazard unit drives into the pipeline.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic select;
    logic flush;
    logic stall;
  } hz_ctrl_t;

  // A load in EX writes a non-zero register that the instruction in ID reads.
  // rt is only a source when the ID instruction actually uses it.
  function automatic logic lu_hit(input logic       ex_mem_read,
                                  input logic [4:0] ex_rt,
                                  input logic [4:0] id_rs,
                                  input logic [4:0] id_rt,
                                  input logic       id_use_rt);
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard statistics.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset, clears the count
//   en_i   count one event this cycle
//   cnt_o  current count, sticks at all-ones
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Increment on event, hold once saturated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_detect_ctrl.sv
// ID-stage hazard controller: load-use bubbles (LOAD_USE_CYCLES per hit),
// whole-pipeline freeze while data memory is busy, and IF flush on taken
// branch / jump. Outputs are decoded in the same cycle as the hazard.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   IDEX_MemRead_i/RegRt_i  load currently in EX and its destination
//   IFID_RegRs_i/RegRt_i    sources of the instruction in ID
//   IFID_UseRt_i            ID instruction reads rt
//   Branch_taken_i, Jump_i  control-flow change resolved in ID
//   mem_stall_i             data memory busy
//   PCWrite_o, IFIDWrite_o  PC and IF/ID write enables
//   select_o                insert bubble into ID/EX
//   Flush_o                 squash the fetched instruction in IF/ID
//   Stall_o                 freeze ID/EX, EX/MEM, MEM/WB
// Option HAZARD_PERF_CNT_EN adds lu_cnt_o, mem_cnt_o, flush_cnt_o counters.
module hazard_detect_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegRt_i,
  input  logic [4:0]       IFID_RegRs_i,
  input  logic [4:0]       IFID_RegRt_i,
  input  logic             IFID_UseRt_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  input  logic             mem_stall_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             select_o,
  output logic             Flush_o,
  output logic             Stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  if ((LOAD_USE_CYCLES < 1) || (LOAD_USE_CYCLES > 7) || (CNT_W < 1)) begin : g_bad_param
    $error("hazard_detect_ctrl: illegal LOAD_USE_CYCLES or CNT_W");
  end

  hz_state_e           state_q, state_d;
  logic [LU_CNT_W-1:0] cnt_q, cnt_d;
  hz_ctrl_t            ctrl_c;
  logic                hit_c;

  assign hit_c = lu_hit(IDEX_MemRead_i, IDEX_RegRt_i, IFID_RegRs_i,
                        IFID_RegRt_i, IFID_UseRt_i);

  // State and bubble counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and same-cycle output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_c  = '{pc_write: 1'b1, ifid_write: 1'b1, select: 1'b0,
                flush: 1'b0, stall: 1'b0};

    case (state_q)
      IDLE: begin
        if (mem_stall_i) begin
          ctrl_c.stall      = 1'b1;
          ctrl_c.pc_write   = 1'b0;
          ctrl_c.ifid_write = 1'b0;
          state_d           = MEM_WAIT;
        end else if (hit_c) begin
          // A pending branch is ignored: it is re-evaluated after the bubble.
          ctrl_c.pc_write   = 1'b0;
          ctrl_c.ifid_write = 1'b0;
          ctrl_c.select     = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            cnt_d   = LU_CNT_W'(LOAD_USE_CYCLES - 1);
            state_d = LU_STALL;
          end
        end else if (Branch_taken_i || Jump_i) begin
          ctrl_c.flush = 1'b1;
        end
      end
      LU_STALL: begin
        ctrl_c.pc_write   = 1'b0;
        ctrl_c.ifid_write = 1'b0;
        ctrl_c.select     = 1'b1;
        // A memory freeze holds the remaining bubble count.
        if (mem_stall_i) begin
          ctrl_c.stall = 1'b1;
        end else begin
          cnt_d = cnt_q - LU_CNT_W'(1);
          if (cnt_q == LU_CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      MEM_WAIT: begin
        ctrl_c.stall      = 1'b1;
        ctrl_c.pc_write   = 1'b0;
        ctrl_c.ifid_write = 1'b0;
        if (!mem_stall_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces a held pipeline with a bubble in ID/EX.
    if (!rst_i) begin
      ctrl_c = '{pc_write: 1'b0, ifid_write: 1'b0, select: 1'b1,
                 flush: 1'b0, stall: 1'b0};
    end
  end

  assign PCWrite_o   = ctrl_c.pc_write;
  assign IFIDWrite_o = ctrl_c.ifid_write;
  assign select_o    = ctrl_c.select;
  assign Flush_o     = ctrl_c.flush;
  assign Stall_o     = ctrl_c.stall;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (ctrl_c.select),
    .cnt_o (lu_cnt_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (ctrl_c.stall),
    .cnt_o (mem_cnt_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (ctrl_c.flush),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_detect_ctrl.sv
// Bench for hazard_detect_ctrl: two instances (LOAD_USE_CYCLES 1 and 3)
// share one stimulus stream; expected output vectors are queued when a
// cycle is driven and compared on the following falling edge.
// Vector order: {PCWrite, IFIDWrite, select, Flush, Stall}.
module tb_hazard_detect_ctrl;

  localparam logic [4:0] DEF  = 5'b11000;
  localparam logic [4:0] BUB  = 5'b00100;
  localparam logic [4:0] FRZ  = 5'b00001;
  localparam logic [4:0] FLS  = 5'b11010;
  localparam logic [4:0] LFZ  = 5'b00101;
  localparam logic [4:0] RSTV = 5'b00100;

  logic       clk;
  logic       rst;
  logic       mr;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       use_rt, br, jmp, ms;

  logic pcw1, ifw1, sel1, fl1, st1;
  logic pcw3, ifw3, sel3, fl3, st3;
  logic [4:0] got1, got3;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lcnt1, mcnt1, fcnt1;
  logic [3:0]  lcnt3, mcnt3, fcnt3;
`endif

  assign got1 = {pcw1, ifw1, sel1, fl1, st1};
  assign got3 = {pcw3, ifw3, sel3, fl3, st3};

  hazard_detect_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (mr),
    .IDEX_RegRt_i   (ex_rt),
    .IFID_RegRs_i   (id_rs),
    .IFID_RegRt_i   (id_rt),
    .IFID_UseRt_i   (use_rt),
    .Branch_taken_i (br),
    .Jump_i         (jmp),
    .mem_stall_i    (ms),
    .PCWrite_o      (pcw1),
    .IFIDWrite_o    (ifw1),
    .select_o       (sel1),
    .Flush_o        (fl1),
    .Stall_o        (st1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_cnt_o       (lcnt1),
    .mem_cnt_o      (mcnt1),
    .flush_cnt_o    (fcnt1)
`endif
  );

  hazard_detect_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (mr),
    .IDEX_RegRt_i   (ex_rt),
    .IFID_RegRs_i   (id_rs),
    .IFID_RegRt_i   (id_rt),
    .IFID_UseRt_i   (use_rt),
    .Branch_taken_i (br),
    .Jump_i         (jmp),
    .mem_stall_i    (ms),
    .PCWrite_o      (pcw3),
    .IFIDWrite_o    (ifw3),
    .select_o       (sel3),
    .Flush_o        (fl3),
    .Stall_o        (st3)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_cnt_o       (lcnt3),
    .mem_cnt_o      (mcnt3),
    .flush_cnt_o    (fcnt3)
`endif
  );

  typedef struct {
    string      tag;
    logic [4:0] e1;
    logic [4:0] e3;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs of both DUTs.
  task automatic step(input string tag, input logic r, input logic m,
                      input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ur, input logic b,
                      input logic j, input logic s,
                      input logic [4:0] e1, input logic [4:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mr = m; ex_rt = ert; id_rs = rs; id_rt = rt;
    use_rt = ur; br = b; jmp = j; ms = s;
    e.tag = tag; e.e1 = e1; e.e3 = e3;
    sb.push_back(e);
  endtask

  // Scoreboard: compare queued expectations on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "/L1"}, 32'(got1), 32'(e.e1));
      chk({e.tag, "/L3"}, 32'(got3), 32'(e.e3));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; mr = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    use_rt = 1'b0; br = 1'b0; jmp = 1'b0; ms = 1'b0;

    //     tag          rst mr ert rs rt ur br j ms   L1    L3
    step("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV, RSTV);
    step("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  DEF);
    step("lu_rs",       1, 1, 2, 2, 0, 0, 0, 0, 0, BUB,  BUB);
    step("lu_b2",       1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  BUB);
    step("lu_b3",       1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  BUB);
    step("lu_done",     1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  DEF);
    step("rt_nouse",    1, 1, 5, 1, 5, 0, 0, 0, 0, DEF,  DEF);
    step("rt_use",      1, 1, 5, 1, 5, 1, 0, 0, 0, BUB,  BUB);
    step("frz1",        1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,  LFZ);
    step("frz2",        1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,  LFZ);
    step("frz3",        1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,  LFZ);
    step("frz4",        1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,  LFZ);
    step("frz_rel",     1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ,  BUB);
    step("resume",      1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  BUB);
    step("resume_end",  1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  DEF);
    step("zero_rt",     1, 1, 0, 0, 0, 1, 0, 0, 0, DEF,  DEF);
    step("lu_br",       1, 1, 3, 3, 0, 0, 1, 0, 0, BUB,  BUB);
    step("br_only",     1, 0, 0, 0, 0, 0, 1, 0, 0, FLS,  BUB);
    step("br_lu3",      1, 0, 0, 0, 0, 0, 1, 0, 0, FLS,  BUB);
    step("br_free",     1, 0, 0, 0, 0, 0, 1, 0, 0, FLS,  FLS);
    step("jump",        1, 0, 0, 0, 0, 0, 0, 1, 0, FLS,  FLS);
    step("ms_prio",     1, 1, 4, 4, 0, 0, 1, 0, 1, FRZ,  FRZ);
    step("mw_exit",     1, 1, 4, 4, 0, 0, 1, 0, 0, FRZ,  FRZ);
    step("lu_redet",    1, 1, 4, 4, 0, 0, 1, 0, 0, BUB,  BUB);

    // L3 now sits in LU_STALL; pulse reset with no clock edge in between.
    begin
      exp_t e;
      @(posedge clk);
      #1;
      mr = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
      use_rt = 1'b0; br = 1'b0; jmp = 1'b0; ms = 1'b0;
      e.tag = "rst_mid_rel"; e.e1 = DEF; e.e3 = DEF;
      sb.push_back(e);
      #1 rst = 1'b0;
      #1;
      chk("rst_async/L1", 32'(got1), 32'(RSTV));
      chk("rst_async/L3", 32'(got3), 32'(RSTV));
      #1 rst = 1'b1;
    end

    step("post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  DEF);
    for (int i = 0; i < 20; i++) begin
      step("flush_run", 1, 0, 0, 0, 0, 0, 1, 0, 0, FLS,  FLS);
    end

    @(posedge clk);
    #1;
    br = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    chk("flush_cnt_sat/L3", 32'(fcnt3), 32'd15);
    chk("flush_cnt/L1",     32'(fcnt1), 32'd20);
    chk("lu_cnt/L3",        32'(lcnt3), 32'd0);
    chk("mem_cnt/L3",       32'(mcnt3), 32'd0);
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      chk("sb_drain", 32'(sb.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
